// File: rtl/panel_pkg.sv
// Shared defaults and key numbering for the front-panel scanner.
// Key k sits on row (k / SENSE) and sense line (k % SENSE).
package panel_pkg;

    localparam int ROWS_DEF  = 6;
    localparam int COLS_DEF  = 6;
    localparam int SENSE_DEF = 3;

    function automatic int key_idx(input int row, input int line, input int sense = SENSE_DEF);
        return row * sense + line;
    endfunction

    // Keys the CPU core decodes by name
    localparam int KEY_START     = key_idx(0, 0);
    localparam int KEY_LOAD_ADDR = key_idx(0, 1);
    localparam int KEY_DEP       = key_idx(1, 1);
    localparam int KEY_EXAM      = key_idx(2, 1);

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: accepts a level change only after DEBOUNCE consecutive
// disagreeing frame updates, and emits one-clock press/release pulses.
module key_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_upd,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (i_upd) begin
                if (i_raw == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                    // This update is the DEBOUNCE-th disagreement: accept it
                    r_level   <= i_raw;
                    r_cnt     <= '0;
                    r_press   <= i_raw;
                    r_release <= ~i_raw;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/panel_scanner.sv
// Front-panel multiplexer: drives LED rows/columns, samples key sense lines
// per row slot, debounces each key per frame and keeps per-key toggle latches.
module panel_scanner
    import panel_pkg::*;
#(
    parameter int                    ROWS        = ROWS_DEF,
    parameter int                    COLS        = COLS_DEF,
    parameter int                    SENSE       = SENSE_DEF,
    parameter int                    SCAN_DIV    = 1024,
    parameter int                    DEBOUNCE    = 3,
    parameter logic [ROWS*SENSE-1:0] TOGGLE_MASK = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ROWS*COLS-1:0]  LEDS,
    output logic [ROWS-1:0]       ROW,
    output logic [COLS-1:0]       COL,
    input  logic [SENSE-1:0]      SENSE_IN,
    output logic [ROWS*SENSE-1:0] KEYS,
    output logic [ROWS*SENSE-1:0] PRESS,
    output logic [ROWS*SENSE-1:0] RELEASE,
    output logic [ROWS*SENSE-1:0] TOGGLE,
    input  logic                  TOG_LOAD,
    input  logic [ROWS*SENSE-1:0] TOG_DATA,
    input  logic                  TOG_CLR,
    output logic                  FRAME
);

    localparam int NK = ROWS * SENSE;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(ROWS + 1);

    logic [PW-1:0]    r_presc;
    logic [SW-1:0]    r_slot;
    logic [ROWS-1:0]  r_row;
    logic [COLS-1:0]  r_col;
    logic [SENSE-1:0] r_sync1;
    logic [SENSE-1:0] r_sync2;
    logic [NK-1:0]    r_raw;
    logic             r_frame;
    logic [NK-1:0]    r_toggle;

    logic             w_tick;
    logic             w_upd;
    logic [ROWS-1:0]  w_row;
    logic [COLS-1:0]  w_col;
    logic [NK-1:0]    w_keys;
    logic [NK-1:0]    w_press;
    logic [NK-1:0]    w_release;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
    assign w_upd  = w_tick && (r_slot == SW'(ROWS));

    // The blank slot (slot == ROWS) matches no row, so drive stays all-zero
    always_comb begin
        w_row = '0;
        w_col = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_slot == SW'(r)) begin
                w_row[r] = 1'b1;
                w_col    = LEDS[r*COLS +: COLS];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_presc <= '0;
            r_slot  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_raw   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_slot <= (r_slot == SW'(ROWS)) ? '0 : r_slot + 1'b1;
            end
            r_row   <= w_row;
            r_col   <= w_col;
            r_sync1 <= SENSE_IN;
            r_sync2 <= r_sync1;
            r_frame <= w_upd;
            // Sample at the end of the row slot, after the lines have settled
            if (w_tick) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (r_slot == SW'(r)) begin
                        r_raw[key_idx(r, 0, SENSE) +: SENSE] <= r_sync2;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NK; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_db (
            .CLK       (CLK),
            .RESET     (RESET),
            .i_upd     (w_upd),
            .i_raw     (r_raw[k]),
            .o_level   (w_keys[k]),
            .o_press   (w_press[k]),
            .o_release (w_release[k])
        );
    end

    // Flip uses the registered PRESS pulse, so a same-cycle load or clear discards it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_toggle <= '0;
        end else if (TOG_CLR) begin
            r_toggle <= '0;
        end else if (TOG_LOAD) begin
            r_toggle <= TOG_DATA & TOGGLE_MASK;
        end else begin
            r_toggle <= r_toggle ^ (w_press & TOGGLE_MASK);
        end
    end

    assign ROW     = r_row;
    assign COL     = r_col;
    assign KEYS    = w_keys;
    assign PRESS   = w_press;
    assign RELEASE = w_release;
    assign TOGGLE  = r_toggle;
    assign FRAME   = r_frame;

endmodule

// File: tb/tb_panel_scanner.sv
// Scoreboard bench for panel_scanner: a key-matrix model drives SENSE_IN from ROW,
// expected per-frame key state is queued and checked on every FRAME pulse.
module tb_panel_scanner;

    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int SENSE = 3;
    localparam int NK    = ROWS * SENSE;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [ROWS*COLS-1:0] LEDS;
    logic [ROWS-1:0]      ROW;
    logic [COLS-1:0]      COL;
    logic [SENSE-1:0]     SENSE_IN;
    logic [NK-1:0]        KEYS;
    logic [NK-1:0]        PRESS;
    logic [NK-1:0]        RELEASE;
    logic [NK-1:0]        TOGGLE;
    logic                 TOG_LOAD;
    logic [NK-1:0]        TOG_DATA;
    logic                 TOG_CLR;
    logic                 FRAME;

    logic [NK-1:0]        pressed;

    typedef struct packed {
        logic [NK-1:0] keys;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] tog;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    panel_scanner #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .SENSE       (SENSE),
        .SCAN_DIV    (4),
        .DEBOUNCE    (3),
        .TOGGLE_MASK (18'h00001)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .LEDS     (LEDS),
        .ROW      (ROW),
        .COL      (COL),
        .SENSE_IN (SENSE_IN),
        .KEYS     (KEYS),
        .PRESS    (PRESS),
        .RELEASE  (RELEASE),
        .TOGGLE   (TOGGLE),
        .TOG_LOAD (TOG_LOAD),
        .TOG_DATA (TOG_DATA),
        .TOG_CLR  (TOG_CLR),
        .FRAME    (FRAME)
    );

    // Key matrix: a held key connects its row drive to its sense line
    always_comb begin
        SENSE_IN = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (ROW[r]) SENSE_IN = SENSE_IN | pressed[r*SENSE +: SENSE];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare on each FRAME, and require PRESS/RELEASE quiet elsewhere
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            if (FRAME) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("frame_keys",    KEYS,    e.keys);
                    chk("frame_press",   PRESS,   e.press);
                    chk("frame_release", RELEASE, e.rel);
                    chk("frame_toggle",  TOGGLE,  e.tog);
                end
            end else begin
                chk("pulse_outside_frame", {PRESS, RELEASE}, 64'd0);
            end
        end
    end

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!FRAME && n < 64);
        chk("frame_arrives", FRAME, 1);
        #1;
    endtask

    task automatic fe(input logic [NK-1:0] k, input logic [NK-1:0] p,
                      input logic [NK-1:0] r, input logic [NK-1:0] t);
        exp_t e;
        e.keys  = k;
        e.press = p;
        e.rel   = r;
        e.tog   = t;
        q.push_back(e);
        wait_frame();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ROWS*COLS-1:0] img;
        int                   s;
        logic [ROWS-1:0]      exp_row;
        logic [COLS-1:0]      exp_col;

        RESET    = 1'b1;
        img      = 36'h00000003F;
        LEDS     = img;
        pressed  = '0;
        TOG_LOAD = 1'b0;
        TOG_CLR  = 1'b0;
        TOG_DATA = '0;
        repeat (3) @(negedge CLK);
        chk("rst_row",    ROW,    0);
        chk("rst_col",    COL,    0);
        chk("rst_keys",   KEYS,   0);
        chk("rst_toggle", TOGGLE, 0);
        chk("rst_frame",  FRAME,  0);
        chk("rst_pulses", {PRESS, RELEASE}, 0);
        RESET = 1'b0;

        // Row/column scan: slot before edge k is ((k-1)/4)%7, frame every 28 edges
        for (int k = 1; k <= 84; k++) begin
            @(negedge CLK);
            s       = ((k - 1) / 4) % 7;
            exp_row = (s < ROWS) ? ROWS'(1 << s) : '0;
            exp_col = (s < ROWS) ? img[s*COLS +: COLS] : '0;
            chk("scan_row",   ROW,   exp_row);
            chk("scan_col",   COL,   exp_col);
            chk("scan_frame", FRAME, (k % 28) == 0);
            if (k == 56) begin
                img  = 36'hFEDCBA987;
                LEDS = img;
            end
        end

        // Key 7 (row 2, line 1) held: accepted on the third frame, then released
        wait_frame();
        pressed[7] = 1'b1;
        fe(18'h0,    18'h0,    18'h0,    18'h0);
        fe(18'h0,    18'h0,    18'h0,    18'h0);
        fe(18'h80,   18'h80,   18'h0,    18'h0);
        fe(18'h80,   18'h0,    18'h0,    18'h0);
        pressed[7] = 1'b0;
        fe(18'h80,   18'h0,    18'h0,    18'h0);
        fe(18'h80,   18'h0,    18'h0,    18'h0);
        fe(18'h0,    18'h0,    18'h80,   18'h0);

        // Two-frame glitches separated by one quiet frame never reach KEYS
        pressed[7] = 1'b1;
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        pressed[7] = 1'b0;
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        pressed[7] = 1'b1;
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        pressed[7] = 1'b0;
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h0, 18'h0);

        // Masked key 0 toggles on each press (flip visible one CLK after PRESS)
        pressed[0] = 1'b1;
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h1, 18'h1, 18'h0, 18'h0);
        pressed[0] = 1'b0;
        fe(18'h1, 18'h0, 18'h0, 18'h1);
        fe(18'h1, 18'h0, 18'h0, 18'h1);
        fe(18'h0, 18'h0, 18'h1, 18'h1);
        pressed[0] = 1'b1;
        fe(18'h0, 18'h0, 18'h0, 18'h1);
        fe(18'h0, 18'h0, 18'h0, 18'h1);
        fe(18'h1, 18'h1, 18'h0, 18'h1);
        pressed[0] = 1'b0;
        fe(18'h1, 18'h0, 18'h0, 18'h0);
        fe(18'h1, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h1, 18'h0);
        // Unmasked key 1 leaves TOGGLE alone
        pressed[1] = 1'b1;
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h0, 18'h0);
        fe(18'h2, 18'h2, 18'h0, 18'h0);
        pressed[1] = 1'b0;
        fe(18'h2, 18'h0, 18'h0, 18'h0);
        fe(18'h2, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h2, 18'h0);

        // Standalone load: only masked bits take TOG_DATA
        TOG_LOAD = 1'b1;
        TOG_DATA = '1;
        @(posedge CLK);
        #1;
        TOG_LOAD = 1'b0;
        chk("load_masked", TOGGLE, 18'h1);

        // Load in the PRESS cycle wins (a flip would give 0), then clear beats load
        wait_frame();
        pressed[0] = 1'b1;
        fe(18'h0, 18'h0, 18'h0, 18'h1);
        fe(18'h0, 18'h0, 18'h0, 18'h1);
        fe(18'h1, 18'h1, 18'h0, 18'h1);
        TOG_LOAD = 1'b1;
        @(posedge CLK);
        #1;
        TOG_LOAD = 1'b0;
        chk("load_beats_press", TOGGLE, 18'h1);
        TOG_CLR  = 1'b1;
        TOG_LOAD = 1'b1;
        @(posedge CLK);
        #1;
        TOG_CLR  = 1'b0;
        TOG_LOAD = 1'b0;
        chk("clr_beats_load", TOGGLE, 18'h0);
        wait_frame();
        pressed[0] = 1'b0;
        fe(18'h1, 18'h0, 18'h0, 18'h0);
        fe(18'h1, 18'h0, 18'h0, 18'h0);
        fe(18'h0, 18'h0, 18'h1, 18'h0);

        // Key 4 (row 1, line 1) held, then reset mid-slot 3
        TOG_LOAD = 1'b1;
        @(posedge CLK);
        #1;
        TOG_LOAD = 1'b0;
        pressed[4] = 1'b1;
        fe(18'h0,  18'h0,  18'h0, 18'h1);
        fe(18'h0,  18'h0,  18'h0, 18'h1);
        fe(18'h10, 18'h10, 18'h0, 18'h1);
        repeat (13) @(negedge CLK);
        chk("pre_reset_row", ROW, 6'b001000);
        RESET = 1'b1;
        #1;
        chk("async_rst_row",    ROW,    0);
        chk("async_rst_col",    COL,    0);
        chk("async_rst_keys",   KEYS,   0);
        chk("async_rst_toggle", TOGGLE, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        fe(18'h0,  18'h0,  18'h0, 18'h0);
        fe(18'h0,  18'h0,  18'h0, 18'h0);
        fe(18'h10, 18'h10, 18'h0, 18'h0);
        fe(18'h10, 18'h0,  18'h0, 18'h0);
        pressed = '0;

        repeat (4) @(negedge CLK);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
